// File: rtl/dram_user_arbiter.sv
// Two-requester round-robin arbiter for the DDR2 user command port: merges
// commands, sequences two-beat write bursts and steers read returns by tag.
module dram_user_arbiter #(
    parameter int DATA_W    = 144,
    parameter int BE_W      = 18,
    parameter int ADDR_W    = 32,
    parameter int TAG_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         phy_ready,
    input  logic                         r0_cmd_valid,
    input  logic                         r0_cmd_rnw,
    input  logic [ADDR_W-1:0]            r0_cmd_addr,
    input  logic [DATA_W-1:0]            r0_wr_data,
    input  logic [BE_W-1:0]              r0_wr_be,
    output logic                         r0_cmd_ack,
    output logic                         r0_rd_valid,
    input  logic                         r1_cmd_valid,
    input  logic                         r1_cmd_rnw,
    input  logic [ADDR_W-1:0]            r1_cmd_addr,
    input  logic [DATA_W-1:0]            r1_wr_data,
    input  logic [BE_W-1:0]              r1_wr_be,
    output logic                         r1_cmd_ack,
    output logic                         r1_rd_valid,
    output logic [DATA_W-1:0]            rd_data,
    output logic                         dram_cmd_valid,
    output logic                         dram_cmd_rnw,
    output logic [ADDR_W-1:0]            dram_cmd_addr,
    output logic [DATA_W-1:0]            dram_wr_data,
    output logic [BE_W-1:0]              dram_wr_be,
    input  logic                         dram_ready,
    input  logic                         dram_rd_valid,
    input  logic [DATA_W-1:0]            dram_rd_data,
    output logic                         rd_err,
    output logic [$clog2(TAG_DEPTH):0]   outstanding
);
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [2:0] ST_INIT     = 3'd0;
    localparam logic [2:0] ST_ARB      = 3'd1;
    localparam logic [2:0] ST_RD_ISSUE = 3'd2;
    localparam logic [2:0] ST_WR_B0    = 3'd3;
    localparam logic [2:0] ST_WR_B1    = 3'd4;

    logic [2:0]        state_reg;
    logic              grant_reg;
    logic              last_grant_reg;
    logic              cmd_valid_reg;
    logic              cmd_rnw_reg;
    logic [ADDR_W-1:0] cmd_addr_reg;
    logic [DATA_W-1:0] wr_data_reg;
    logic [BE_W-1:0]   wr_be_reg;

    logic              tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;

    logic [1:0]        rd_valid_reg;
    logic [DATA_W-1:0] rd_data_reg;
    logic              rd_err_reg;

    logic [1:0]        req_valid;
    logic [1:0]        req_rnw;
    logic [1:0]        eligible;
    logic [1:0]        ack_vec;
    logic              fifo_full;
    logic              fifo_empty;
    logic              arb_go;
    logic              arb_pick;
    logic              xfer;
    logic              beat1_load;
    logic              ack_id;
    logic              ack_any;
    logic              push;
    logic              pop;
    logic              sel_rnw;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic [BE_W-1:0]   sel_be;

    assign req_valid  = {r1_cmd_valid, r0_cmd_valid};
    assign req_rnw    = {r1_cmd_rnw, r0_cmd_rnw};
    assign fifo_full  = (count_reg == CNT_W'(TAG_DEPTH));
    assign fifo_empty = (count_reg == '0);

    // A full tag FIFO only blocks reads; writes remain eligible.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign eligible[gi] = req_valid[gi] && (!req_rnw[gi] || !fifo_full);
            assign ack_vec[gi]  = ack_any && (ack_id == gi[0]);
        end
    endgenerate

    assign arb_go     = (state_reg == ST_ARB) && (eligible != 2'b00);
    assign arb_pick   = (eligible == 2'b11) ? !last_grant_reg : eligible[1];
    assign xfer       = cmd_valid_reg && dram_ready;
    assign beat1_load = (state_reg == ST_WR_B0) && xfer;
    assign ack_id     = (state_reg == ST_ARB) ? arb_pick : grant_reg;
    assign ack_any    = !reset && (arb_go || beat1_load);
    assign push       = (state_reg == ST_RD_ISSUE) && xfer;
    assign pop        = dram_rd_valid && !fifo_empty;

    assign sel_rnw  = ack_id ? r1_cmd_rnw  : r0_cmd_rnw;
    assign sel_addr = ack_id ? r1_cmd_addr : r0_cmd_addr;
    assign sel_data = ack_id ? r1_wr_data  : r0_wr_data;
    assign sel_be   = ack_id ? r1_wr_be    : r0_wr_be;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_INIT;
            grant_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            cmd_valid_reg  <= 1'b0;
            cmd_rnw_reg    <= 1'b0;
            cmd_addr_reg   <= '0;
            wr_data_reg    <= '0;
            wr_be_reg      <= '0;
        end else begin
            case (state_reg)
                ST_INIT: begin
                    if (phy_ready) state_reg <= ST_ARB;
                end
                ST_ARB: begin
                    if (arb_go) begin
                        grant_reg     <= arb_pick;
                        cmd_valid_reg <= 1'b1;
                        cmd_rnw_reg   <= sel_rnw;
                        cmd_addr_reg  <= sel_addr;
                        wr_data_reg   <= sel_data;
                        wr_be_reg     <= sel_be;
                        state_reg     <= sel_rnw ? ST_RD_ISSUE : ST_WR_B0;
                    end
                end
                ST_RD_ISSUE: begin
                    if (xfer) begin
                        cmd_valid_reg  <= 1'b0;
                        last_grant_reg <= grant_reg;
                        state_reg      <= ST_ARB;
                    end
                end
                ST_WR_B0: begin
                    // Address is held; only the data beat advances.
                    if (xfer) begin
                        wr_data_reg <= sel_data;
                        wr_be_reg   <= sel_be;
                        state_reg   <= ST_WR_B1;
                    end
                end
                ST_WR_B1: begin
                    if (xfer) begin
                        cmd_valid_reg  <= 1'b0;
                        last_grant_reg <= grant_reg;
                        state_reg      <= ST_ARB;
                    end
                end
                default: state_reg <= ST_INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr_reg] <= grant_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            rd_valid_reg <= '0;
            rd_data_reg  <= '0;
            rd_err_reg   <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg    <= count_reg + CNT_W'(push) - CNT_W'(pop);
            rd_valid_reg <= '0;
            if (dram_rd_valid) begin
                rd_data_reg <= dram_rd_data;
                if (fifo_empty) rd_err_reg <= 1'b1;
                else            rd_valid_reg[tag_mem[rd_ptr_reg]] <= 1'b1;
            end
        end
    end

    assign r0_cmd_ack     = ack_vec[0];
    assign r1_cmd_ack     = ack_vec[1];
    assign r0_rd_valid    = rd_valid_reg[0];
    assign r1_rd_valid    = rd_valid_reg[1];
    assign rd_data        = rd_data_reg;
    assign dram_cmd_valid = cmd_valid_reg;
    assign dram_cmd_rnw   = cmd_rnw_reg;
    assign dram_cmd_addr  = cmd_addr_reg;
    assign dram_wr_data   = wr_data_reg;
    assign dram_wr_be     = wr_be_reg;
    assign rd_err         = rd_err_reg;
    assign outstanding    = count_reg;
endmodule

// File: tb/tb_dram_user_arbiter.sv
// Directed bench for dram_user_arbiter: queued requester commands, a DRAM-side
// transfer log and hand-computed expectations checked with immediate assertions.
module tb_dram_user_arbiter;
    logic         clk = 1'b0;
    logic         reset;
    logic         phy_ready;
    logic         r0_cmd_valid, r0_cmd_rnw, r0_cmd_ack, r0_rd_valid;
    logic [31:0]  r0_cmd_addr;
    logic [143:0] r0_wr_data;
    logic [17:0]  r0_wr_be;
    logic         r1_cmd_valid, r1_cmd_rnw, r1_cmd_ack, r1_rd_valid;
    logic [31:0]  r1_cmd_addr;
    logic [143:0] r1_wr_data;
    logic [17:0]  r1_wr_be;
    logic [143:0] rd_data;
    logic         dram_cmd_valid, dram_cmd_rnw;
    logic [31:0]  dram_cmd_addr;
    logic [143:0] dram_wr_data;
    logic [17:0]  dram_wr_be;
    logic         dram_ready;
    logic         dram_rd_valid;
    logic [143:0] dram_rd_data;
    logic         rd_err;
    logic [4:0]   outstanding;

    dram_user_arbiter dut (
        .clk(clk), .reset(reset), .phy_ready(phy_ready),
        .r0_cmd_valid(r0_cmd_valid), .r0_cmd_rnw(r0_cmd_rnw), .r0_cmd_addr(r0_cmd_addr),
        .r0_wr_data(r0_wr_data), .r0_wr_be(r0_wr_be), .r0_cmd_ack(r0_cmd_ack),
        .r0_rd_valid(r0_rd_valid),
        .r1_cmd_valid(r1_cmd_valid), .r1_cmd_rnw(r1_cmd_rnw), .r1_cmd_addr(r1_cmd_addr),
        .r1_wr_data(r1_wr_data), .r1_wr_be(r1_wr_be), .r1_cmd_ack(r1_cmd_ack),
        .r1_rd_valid(r1_rd_valid),
        .rd_data(rd_data),
        .dram_cmd_valid(dram_cmd_valid), .dram_cmd_rnw(dram_cmd_rnw),
        .dram_cmd_addr(dram_cmd_addr), .dram_wr_data(dram_wr_data), .dram_wr_be(dram_wr_be),
        .dram_ready(dram_ready), .dram_rd_valid(dram_rd_valid), .dram_rd_data(dram_rd_data),
        .rd_err(rd_err), .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rnw;
        logic [31:0]  addr;
        logic [143:0] d0;
        logic [143:0] d1;
        logic [17:0]  be0;
        logic [17:0]  be1;
    } req_t;

    typedef struct {
        logic         rnw;
        logic [31:0]  addr;
        logic [143:0] data;
        logic [17:0]  be;
        int           cyc;
    } xfer_t;

    req_t  q0[$];
    req_t  q1[$];
    xfer_t xfer_q[$];
    logic  ph0 = 1'b0, ph1 = 1'b0;
    logic  prev_a0 = 1'b0, prev_a1 = 1'b0;
    int    cyc = 0, acks0 = 0, acks1 = 0, dbl_ack = 0;
    int    errors = 0, checks = 0;

    localparam logic [143:0] PAT_AA = {18{8'hAA}};
    localparam logic [143:0] PAT_55 = {18{8'h55}};

    task automatic check(input string tag, input logic [143:0] got, input logic [143:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic req_t rd_req(input logic [31:0] a);
        req_t r;
        r = '{rnw: 1'b1, addr: a, d0: '0, d1: '0, be0: '0, be1: '0};
        return r;
    endfunction

    function automatic req_t wr_req(input logic [31:0] a, input logic [143:0] x0,
                                    input logic [17:0] b0, input logic [143:0] x1,
                                    input logic [17:0] b1);
        req_t r;
        r = '{rnw: 1'b0, addr: a, d0: x0, d1: x1, be0: b0, be1: b1};
        return r;
    endfunction

    task automatic drive();
        r0_cmd_valid = (q0.size() > 0);
        r1_cmd_valid = (q1.size() > 0);
        if (q0.size() > 0) begin
            r0_cmd_rnw  = q0[0].rnw;
            r0_cmd_addr = q0[0].addr;
            r0_wr_data  = ph0 ? q0[0].d1 : q0[0].d0;
            r0_wr_be    = ph0 ? q0[0].be1 : q0[0].be0;
        end
        if (q1.size() > 0) begin
            r1_cmd_rnw  = q1[0].rnw;
            r1_cmd_addr = q1[0].addr;
            r1_wr_data  = ph1 ? q1[0].d1 : q1[0].d0;
            r1_wr_be    = ph1 ? q1[0].be1 : q1[0].be0;
        end
    endtask

    // Sample handshakes on the falling edge, then let requesters advance after the rising edge.
    task automatic tick();
        logic a0, a1;
        @(negedge clk);
        a0 = r0_cmd_ack;
        a1 = r1_cmd_ack;
        if (dram_cmd_valid && dram_ready)
            xfer_q.push_back('{rnw: dram_cmd_rnw, addr: dram_cmd_addr, data: dram_wr_data,
                               be: dram_wr_be, cyc: cyc});
        if (a0) acks0++;
        if (a1) acks1++;
        if ((a0 && prev_a0) || (a1 && prev_a1)) dbl_ack++;
        prev_a0 = a0;
        prev_a1 = a1;
        @(posedge clk);
        #1;
        cyc++;
        if (a0 && q0.size() > 0) begin
            if (q0[0].rnw || ph0) begin void'(q0.pop_front()); ph0 = 1'b0; end
            else ph0 = 1'b1;
        end
        if (a1 && q1.size() > 0) begin
            if (q1[0].rnw || ph1) begin void'(q1.pop_front()); ph1 = 1'b0; end
            else ph1 = 1'b1;
        end
        drive();
    endtask

    task automatic do_return(input logic [143:0] d, input logic exp_tag, input string tag);
        dram_rd_valid = 1'b1;
        dram_rd_data  = d;
        tick();
        dram_rd_valid = 1'b0;
        check({tag, "_r0v"}, 144'(r0_rd_valid), 144'(!exp_tag));
        check({tag, "_r1v"}, 144'(r1_rd_valid), 144'(exp_tag));
        check({tag, "_data"}, rd_data, d);
    endtask

    initial begin
        reset = 1'b1; phy_ready = 1'b0; dram_ready = 1'b1;
        dram_rd_valid = 1'b0; dram_rd_data = '0;
        r0_cmd_rnw = 1'b0; r0_cmd_addr = '0; r0_wr_data = '0; r0_wr_be = '0;
        r1_cmd_rnw = 1'b0; r1_cmd_addr = '0; r1_wr_data = '0; r1_wr_be = '0;
        drive();
        for (int i = 0; i < 5; i++) tick();
        check("reset_cmd_valid", 144'(dram_cmd_valid), 144'(0));
        check("reset_outstanding", 144'(outstanding), 144'(0));
        check("reset_rd_err", 144'(rd_err), 144'(0));

        // Calibration gate: both requesters waiting, nothing may move.
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            q0.push_back(rd_req(32'h100));
            q1.push_back(rd_req(32'h200));
        end
        drive();
        for (int i = 0; i < 20; i++) tick();
        check("init_no_ack", 144'(acks0 + acks1), 144'(0));
        check("init_no_xfer", 144'(xfer_q.size()), 144'(0));
        check("init_cmd_valid", 144'(dram_cmd_valid), 144'(0));

        // Continuous reads alternate, starting with r0.
        phy_ready = 1'b1;
        for (int t = 0; t < 100 && xfer_q.size() < 6; t++) tick();
        check("rr_count", 144'(xfer_q.size()), 144'(6));
        for (int k = 0; k < 6; k++) begin
            check("rr_addr", 144'(xfer_q[k].addr), (k % 2 == 0) ? 144'h100 : 144'h200);
            check("rr_rnw", 144'(xfer_q[k].rnw), 144'(1));
        end
        check("rr_single_acks", 144'(dbl_ack), 144'(0));
        check("rr_acks", 144'(acks0 * 16 + acks1), 144'h33);
        check("rr_outstanding", 144'(outstanding), 144'(6));
        for (int k = 0; k < 6; k++) do_return(144'h11 + 144'(k), k[0], "rr_ret");
        check("rr_drained", 144'(outstanding), 144'(0));

        // Write burst held by dram_ready, beat1 follows beat0 with no r0 read between.
        xfer_q.delete();
        dram_ready = 1'b0;
        q1.push_back(wr_req(32'h400, PAT_AA, 18'h3FFFF, PAT_55, 18'h15555));
        drive();
        tick();
        q0.push_back(rd_req(32'h100));
        q0.push_back(rd_req(32'h100));
        drive();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_valid", 144'(dram_cmd_valid), 144'(1));
            check("hold_data", dram_wr_data, PAT_AA);
            check("hold_addr", 144'(dram_cmd_addr), 144'h400);
        end
        dram_ready = 1'b1;
        for (int t = 0; t < 40 && xfer_q.size() < 4; t++) tick();
        check("wr_count", 144'(xfer_q.size()), 144'(4));
        check("wr_b0_data", xfer_q[0].data, PAT_AA);
        check("wr_b0_be", 144'(xfer_q[0].be), 144'h3FFFF);
        check("wr_b1_data", xfer_q[1].data, PAT_55);
        check("wr_b1_be", 144'(xfer_q[1].be), 144'h15555);
        check("wr_b1_addr", 144'(xfer_q[1].addr), 144'h400);
        check("wr_b1_rnw", 144'(xfer_q[1].rnw), 144'(0));
        check("wr_b1_adjacent", 144'(xfer_q[1].cyc), 144'(xfer_q[0].cyc + 1));
        check("wr_then_rd", 144'(xfer_q[2].addr), 144'h100);
        do_return(144'hA1, 1'b0, "wr_ret");
        do_return(144'hA2, 1'b0, "wr_ret");

        // Fill the tag FIFO; the 17th read stalls while a write still proceeds.
        xfer_q.delete();
        for (int i = 0; i < 17; i++) q0.push_back(rd_req(32'h300));
        drive();
        for (int t = 0; t < 80 && xfer_q.size() < 16; t++) tick();
        for (int i = 0; i < 6; i++) tick();
        check("full_count", 144'(xfer_q.size()), 144'(16));
        check("full_outstanding", 144'(outstanding), 144'(16));
        check("full_stalled", 144'(q0.size()), 144'(1));
        q1.push_back(wr_req(32'h500, 144'h1234, 18'h00003, 144'h5678, 18'h0000C));
        drive();
        for (int t = 0; t < 20 && xfer_q.size() < 18; t++) tick();
        tick();
        check("full_wr_count", 144'(xfer_q.size()), 144'(18));
        check("full_wr_addr", 144'(xfer_q[16].addr), 144'h500);
        check("full_wr_b1", xfer_q[17].data, 144'h5678);
        check("full_still_stalled", 144'(q0.size()), 144'(1));
        do_return(144'hBEEF, 1'b0, "full_ret");
        check("full_after_pop", 144'(outstanding), 144'(15));
        for (int t = 0; t < 20 && xfer_q.size() < 19; t++) tick();
        check("full_resume_addr", 144'(xfer_q[18].addr), 144'h300);
        check("full_resume_out", 144'(outstanding), 144'(16));
        for (int k = 0; k < 16; k++) do_return(144'h3000 + 144'(k), 1'b0, "full_drain");
        check("full_drained", 144'(outstanding), 144'(0));

        // Mixed issue order r0,r1,r1,r0 routes returns back in the same order.
        xfer_q.delete();
        for (int k = 0; k < 4; k++) begin
            if (k == 1 || k == 2) q1.push_back(rd_req(32'h600 + 32'(k)));
            else                  q0.push_back(rd_req(32'h600 + 32'(k)));
            drive();
            for (int t = 0; t < 20 && xfer_q.size() < k + 1; t++) tick();
        end
        check("mix_count", 144'(xfer_q.size()), 144'(4));
        check("mix_out", 144'(outstanding), 144'(4));
        do_return(144'h1, 1'b0, "mix_ret1");
        do_return(144'h2, 1'b1, "mix_ret2");
        do_return(144'h3, 1'b1, "mix_ret3");
        do_return(144'h4, 1'b0, "mix_ret4");

        // Stray return with nothing outstanding.
        dram_rd_valid = 1'b1;
        dram_rd_data  = 144'hDEAD;
        tick();
        dram_rd_valid = 1'b0;
        check("err_set", 144'(rd_err), 144'(1));
        check("err_no_r0v", 144'(r0_rd_valid), 144'(0));
        check("err_no_r1v", 144'(r1_rd_valid), 144'(0));
        check("err_out", 144'(outstanding), 144'(0));
        for (int i = 0; i < 3; i++) tick();
        check("err_sticky", 144'(rd_err), 144'(1));

        // Reset while beat1 is pending abandons the burst.
        dram_ready = 1'b0;
        q0.push_back(wr_req(32'h700, 144'hA1, 18'h1, 144'hB2, 18'h2));
        drive();
        tick();
        dram_ready = 1'b1;
        tick();
        dram_ready = 1'b0;
        check("b1_pending_data", dram_wr_data, 144'hB2);
        check("b1_pending_valid", 144'(dram_cmd_valid), 144'(1));
        reset = 1'b1;
        tick();
        check("rst_cmd_valid", 144'(dram_cmd_valid), 144'(0));
        check("rst_wr_data", dram_wr_data, 144'(0));
        check("rst_addr", 144'(dram_cmd_addr), 144'(0));
        check("rst_acks", 144'({r0_cmd_ack, r1_cmd_ack}), 144'(0));
        check("rst_rd_err", 144'(rd_err), 144'(0));
        check("rst_rd_data", rd_data, 144'(0));
        reset = 1'b0;
        dram_ready = 1'b1;
        xfer_q.delete();
        for (int i = 0; i < 5; i++) tick();
        check("rst_no_beats", 144'(xfer_q.size()), 144'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
